fetch_ctrl: RTL
===============

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, word-address width of instruction memory.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous, active-low reset.
REQ-005 SHALL have port redirect, input, 1, branch/flush request, valid for one cycle.
REQ-006 SHALL have port branch_target, input, 32, byte address used when redirect=1.
REQ-007 SHALL have port id_ready, input, 1, decode accepts if_instr this cycle.
REQ-008 SHALL have port imem_en, output, 1, instruction memory read enable.
REQ-009 SHALL have port imem_addr, output, ADDR_WIDTH, word address = fetch byte address [ADDR_WIDTH+1:2].
REQ-010 SHALL have port imem_rdata, input, 32, read data, one cycle after an imem_en=1 cycle.
REQ-011 SHALL have port if_valid, output, 1, if_pc/if_instr hold a valid instruction.
REQ-012 SHALL have port if_pc, output, 32, byte PC of if_instr.
REQ-013 SHALL have port if_instr, output, 32, fetched instruction.
REQ-014 SHALL have port misaligned, output, 1, one-cycle pulse, accepted redirect with branch_target[1:0]!=0.

Function
REQ-015 SHALL implement states BOOT, RUN, REDIR. BOOT->RUN after one cycle. RUN->REDIR on redirect. REDIR->RUN next cycle.
REQ-016 SHALL issue the read at RESET_PC in BOOT. imem_en=1 in BOOT.
REQ-017 SHALL use a 1-cycle memory model. A read issued in cycle t returns imem_rdata in t+1, tagged with the PC issued in t.
REQ-018 SHALL hold a 1-entry skid buffer. Returned data goes to the output register when it is empty or being consumed (if_valid && id_ready); otherwise it goes to the skid buffer.
REQ-019 SHALL move the skid entry to the output register on consume, before newly returned data. Program order is preserved.
REQ-020 SHALL issue a read in RUN only if (if_valid + skid_valid + inflight - consume) < 2. The skid buffer never overflows.
REQ-021 SHALL increment next-fetch PC by 4 per issued read, modulo 2^32. Memory address wraps within 2^ADDR_WIDTH words.
REQ-022 SHALL sustain 1 instruction per cycle when id_ready is held at 1.
REQ-023 SHALL hold if_valid/if_pc/if_instr stable while if_valid=1 and id_ready=0.
REQ-024 On redirect, SHALL in the same cycle:
  - drive imem_addr from branch_target with imem_en=1;
  - clear the skid buffer;
  - discard the in-flight read;
  - set if_valid=0 on the next edge.
  The next-fetch PC becomes branch_target+4.
REQ-025 SHALL give redirect priority over id_ready=0 and over a pending consume. The consume in the redirect cycle still completes.
REQ-026 SHALL force branch_target[1:0] to 00 for fetch and pulse misaligned.
REQ-027 SHALL deliver the first target instruction on if_valid two edges after the redirect edge, with id_ready=1.
REQ-028 SHALL honour back-to-back redirects. Only the last target is fetched; no stale instruction appears.

Reset
REQ-029 While rst=0, SHALL force: state=BOOT, next-fetch PC=RESET_PC, if_valid=0, skid_valid=0, inflight=0, if_pc=0, if_instr=0, misaligned=0.
REQ-030 SHALL drive imem_en=0 while rst=0. A read in flight at reset assertion is discarded.
REQ-031 SHALL perform the BOOT fetch in the first cycle after rst deassertion.

Structure
REQ-032 SHALL place the state enum and the NOP constant (32'h0000_0013) in package pipe_pkg.
REQ-033 SHALL implement the skid buffer as sub-module fetch_skid (1 entry, data+pc, push/pop/clear).
REQ-034 SHALL register all state. The imem_addr/imem_en combinational path is limited to redirect muxing.

Verification
REQ-035 Reset release, RESET_PC=0, id_ready=1 -> if_pc sequence 0x0, 0x4, 0x8 on consecutive cycles starting 2 edges after release.
REQ-036 id_ready=0 for 3 cycles while streaming at PC 0x10:
  - if_pc holds 0x10;
  - at most one read completes into skid;
  - on release, if_pc is 0x14, then 0x18, with no gap or duplicate.
REQ-037 Redirect to 0x100 while skid is full and id_ready=0:
  - skid is cleared;
  - if_valid=0 next cycle;
  - if_pc=0x100 two edges later;
  - old PCs never reappear.
REQ-038 Redirect to 0x102 -> misaligned pulses 1 cycle and if_pc=0x100.
REQ-039 Redirects on two consecutive cycles to 0x40 then 0x80 -> first valid if_pc is 0x80.
REQ-040 Assert rst mid-stream with skid full -> outputs zero immediately (asynchronous); after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the instruction fetch front end.
package pipe_pkg;

    // Fetch controller sequencing states.
    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_REDIR = 2'd2
    } fetch_state_e;

    // Canonical RISC-V NOP (addi x0, x0, 0).
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Force a byte address onto a 32-bit word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry skid buffer holding an instruction word and its byte PC.
// Clear has priority over push; a simultaneous push and pop reloads the slot.
module fetch_skid
    import pipe_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        pop,
    input  logic        clear,
    input  logic [31:0] push_data,
    input  logic [31:0] push_pc,
    output logic        valid,
    output logic [31:0] data,
    output logic [31:0] pc
);

    logic        valid_q, valid_d;
    logic [31:0] data_q,  data_d;
    logic [31:0] pc_q,    pc_d;

    // Next-entry selection: clear, then load, then drain, else hold.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        pc_d    = pc_q;
        if (clear) begin
            valid_d = 1'b0;
        end else if (push) begin
            valid_d = 1'b1;
            data_d  = push_data;
            pc_d    = push_pc;
        end else if (pop) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Entry storage; an empty slot resets to a harmless NOP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            data_q  <= NOP_INSTR;
            pc_q    <= 32'h0000_0000;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            pc_q    <= pc_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;
    assign pc    = pc_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: issues word reads to a 1-cycle memory, keeps
// at most two instructions buffered (output register + skid) and handles
// branch redirects, which flush everything older than the target fetch.
module fetch_ctrl
    import pipe_pkg::*;
#(
    parameter int          ADDR_WIDTH = 10,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  redirect,
    input  logic [31:0]           branch_target,
    input  logic                  id_ready,
    output logic                  imem_en,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [31:0]           imem_rdata,
    output logic                  if_valid,
    output logic [31:0]           if_pc,
    output logic [31:0]           if_instr,
    output logic                  misaligned
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;               // next sequential fetch byte address
    logic         inflight_q, inflight_d;   // read issued last cycle returns now
    logic [31:0]  inflight_pc_q, inflight_pc_d;
    logic         if_valid_q, if_valid_d;
    logic [31:0]  if_pc_q, if_pc_d;
    logic [31:0]  if_instr_q, if_instr_d;
    logic         misaligned_q, misaligned_d;

    logic         consume_s;
    logic [1:0]   occ_s;
    logic         issue_s;
    logic         out_free_s;
    logic         skid_push_s, skid_pop_s, skid_clear_s;
    logic         skid_valid_s;
    logic [31:0]  skid_data_s, skid_pc_s;

    fetch_skid u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (skid_push_s),
        .pop       (skid_pop_s),
        .clear     (skid_clear_s),
        .push_data (imem_rdata),
        .push_pc   (inflight_pc_q),
        .valid     (skid_valid_s),
        .data      (skid_data_s),
        .pc        (skid_pc_s)
    );

    // Issue decision and memory request; only redirect muxes the address.
    always_comb begin
        consume_s = if_valid_q & id_ready;
        occ_s     = {1'b0, if_valid_q} + {1'b0, skid_valid_s}
                  + {1'b0, inflight_q} - {1'b0, consume_s};
        case (state_q)
            ST_BOOT:           issue_s = 1'b1;
            ST_RUN, ST_REDIR:  issue_s = (occ_s < 2'd2);
            default:           issue_s = 1'b0;
        endcase
        imem_en = rst & (redirect | issue_s);
        if (redirect) begin
            imem_addr = branch_target[ADDR_WIDTH+1:2];
        end else begin
            imem_addr = pc_q[ADDR_WIDTH+1:2];
        end
    end

    // Next-state, fetch PC and output/skid steering.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        if_valid_d    = if_valid_q;
        if_pc_d       = if_pc_q;
        if_instr_d    = if_instr_q;
        misaligned_d  = 1'b0;
        skid_push_s   = 1'b0;
        skid_pop_s    = 1'b0;
        skid_clear_s  = 1'b0;
        out_free_s    = ~if_valid_q | consume_s;

        case (state_q)
            ST_BOOT:  state_d = ST_RUN;
            ST_RUN:   state_d = ST_RUN;
            ST_REDIR: state_d = ST_RUN;
            default:  state_d = ST_BOOT;
        endcase

        if (redirect) begin
            // Flush: the returning read and any buffered work are stale.
            state_d       = ST_REDIR;
            pc_d          = word_align(branch_target) + 32'd4;
            inflight_d    = 1'b1;
            inflight_pc_d = word_align(branch_target);
            if_valid_d    = 1'b0;
            skid_clear_s  = 1'b1;
            misaligned_d  = (branch_target[1:0] != 2'b00);
        end else begin
            if (issue_s) begin
                pc_d          = pc_q + 32'd4;
                inflight_d    = 1'b1;
                inflight_pc_d = word_align(pc_q);
            end else begin
                inflight_d    = 1'b0;
            end

            if (out_free_s) begin
                // Older skid entry goes out first, returning data backfills it.
                if (skid_valid_s) begin
                    if_valid_d  = 1'b1;
                    if_pc_d     = skid_pc_s;
                    if_instr_d  = skid_data_s;
                    skid_pop_s  = 1'b1;
                    skid_push_s = inflight_q;
                end else if (inflight_q) begin
                    if_valid_d  = 1'b1;
                    if_pc_d     = inflight_pc_q;
                    if_instr_d  = imem_rdata;
                end else begin
                    if_valid_d  = 1'b0;
                end
            end else begin
                // Output stalled: park the returning word in the skid slot.
                skid_push_s = inflight_q;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= 32'h0000_0000;
            if_valid_q    <= 1'b0;
            if_pc_q       <= 32'h0000_0000;
            if_instr_q    <= 32'h0000_0000;
            misaligned_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            if_valid_q    <= if_valid_d;
            if_pc_q       <= if_pc_d;
            if_instr_q    <= if_instr_d;
            misaligned_q  <= misaligned_d;
        end
    end

    assign if_valid   = if_valid_q;
    assign if_pc      = if_pc_q;
    assign if_instr   = if_instr_q;
    assign misaligned = misaligned_q;

endmodule
